// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and the matching transmitter:
// state encoding, data width and the baud divider rounding function.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int div_round(input int clk_hz, input int baud, input int oversample);
        return (clk_hz + (baud * oversample) / 2) / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running 0..DIV-1 counter while enabled,
// one-clock tick at DIV-1, held at 0 while disabled.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int DIV = div_round(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    // Divider counter; restarts from 0 whenever the receiver is idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, oversampled with 3-sample majority voting
// around mid-bit. Returns to IDLE at the stop-bit mid-sample so back-to-back
// frames are accepted.
// Optional: define UART_RX_PARITY_EN to receive an even parity bit (8E1).
//
//  state     | meaning
//  IDLE      | line idle, waiting for a low on rx_s
//  START     | validating start bit; majority high means a glitch
//  DATA      | shifting in 8 data bits, LSB first
//  PARITY    | sampling the parity bit (parity build only)
//  STOP      | sampling the stop bit, issuing valid / frame_err / parity_err
//  WAIT_HIGH | stop bit was low; waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;

    state_t            state, state_nxt;
    logic              rx_meta, rx_s;
    logic              tick, wrap, decide;
    logic [SCW-1:0]    sc;
    logic [2:0]        samp;
    logic              bit_maj;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              valid_set, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic              par_bit;
    logic              perr_set;
`endif

    uart_baud_tick #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state != IDLE),
        .tick  (tick)
    );

    assign wrap    = tick && (sc == SCW'(OVERSAMPLE - 1));
    assign bit_maj = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign busy    = (state != IDLE);

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    // Sample counter within a bit, plus the three mid-bit samples. The
    // decision strobe fires the clock after the third sample is captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc     <= '0;
            samp   <= '0;
            decide <= 1'b0;
        end else if (state == IDLE) begin
            sc     <= '0;
            decide <= 1'b0;
        end else begin
            decide <= tick && (sc == SCW'(MID + 1));
            if (tick) begin
                sc <= wrap ? '0 : sc + 1'b1;
                if (sc == SCW'(MID - 1)) samp[0] <= rx_s;
                if (sc == SCW'(MID))     samp[1] <= rx_s;
                if (sc == SCW'(MID + 1)) samp[2] <= rx_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nxt = state;
        valid_set = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (decide && bit_maj) state_nxt = IDLE;
                else if (wrap)         state_nxt = DATA;
            end
            DATA: begin
                if (wrap && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (wrap) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (decide) begin
                    if (bit_maj) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if ((^shreg) ^ par_bit) perr_set  = 1'b1;
                        else                    valid_set = 1'b1;
`else
                        valid_set = 1'b1;
`endif
                    end else begin
                        state_nxt = WAIT_HIGH;
                        ferr_set  = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == START)              bit_idx <= '0;
            else if (state == DATA && wrap)  bit_idx <= bit_idx + 1'b1;
            if (state == DATA && decide)     shreg   <= {bit_maj, shreg[DATA_W-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Received parity bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit <= 1'b0;
        end else if (state == PARITY && decide) begin
            par_bit <= bit_maj;
        end
    end

    // Parity error strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_err <= 1'b0;
        else        parity_err <= perr_set;
    end
`else
    assign parity_err = 1'b0;
`endif

    // Registered strobes; data only changes on a good frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= valid_set;
            frame_err <= ferr_set;
            if (valid_set) data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx. Runs the receiver at BAUD=312500 from a
// 25 MHz clock: DIV=(25e6+2.5e6)/5e6=5, one bit = 5*16*40 ns = 3200 ns.
// Honors UART_RX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_NS = 3200;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx #(
        .CLK_HZ     (25000000),
        .BAUD       (312500),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        int         kind;   // 0 valid, 1 frame_err, 2 parity_err
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    time  t_last = 0;
    time  t_prev = 0;
    logic strobe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        #(BIT_NS);
`endif
        rxd = stop_bit;
        #(BIT_NS);
    endtask

    // Monitor: pops the scoreboard whenever any strobe appears.
    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        if (reset) begin
            n = int'(valid) + int'(frame_err) + int'(parity_err);
            if (n != 0) begin
                check("strobe_exclusive", n, 1);
                check("strobe_one_cycle", {31'd0, strobe_prev}, 0);
                kind = valid ? 0 : (frame_err ? 1 : 2);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: kind %0d data %02h, nothing expected at %0t",
                             kind, data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", kind, e.kind);
                    check("strobe_data", {24'd0, data}, {24'd0, e.data});
                    check("busy_at_strobe", {31'd0, busy}, (kind == 1) ? 1 : 0);
                end
                if (valid) begin
                    t_prev = t_last;
                    t_last = $time;
                end
            end
            strobe_prev = (n != 0);
        end else begin
            strobe_prev = 1'b0;
        end
    end

    initial begin
        time t0;
        logic [7:0] last_good;
        last_good = 8'h00;

        // Reset with idle line.
        rxd   = 1'b1;
        reset = 1'b0;
        #100;
        check("rst_data", {24'd0, data}, 0);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_parity_err", {31'd0, parity_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        #100;
        reset = 1'b1;
        #10000;
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_data", {24'd0, data}, 0);

        // Single frame 8'hA5 with latency window.
        expect_ev(0, 8'hA5);
        last_good = 8'hA5;
        t0 = $time;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                #(BIT_NS * 3);
                check("a5_busy_mid", {31'd0, busy}, 1);
            end
        join
        check("a5_latency_lo", {31'd0, (t_last - t0) >= time'(BIT_NS * FRAME_BITS - 1600)}, 1);
        check("a5_latency_hi", {31'd0, (t_last - t0) <= time'(BIT_NS * FRAME_BITS - 1600 + 1200)}, 1);
        #(BIT_NS * 2);
        check("a5_busy_after", {31'd0, busy}, 0);

        // Back-to-back 8'h00 then 8'hFF.
        expect_ev(0, 8'h00);
        expect_ev(0, 8'hFF);
        last_good = 8'hFF;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        #(BIT_NS * 2);
        check("b2b_spacing", {31'd0, ((t_last - t_prev) >= time'(BIT_NS * FRAME_BITS - 80)) &&
                                     ((t_last - t_prev) <= time'(BIT_NS * FRAME_BITS + 80))}, 1);
        check("b2b_data", {24'd0, data}, 8'hFF);

        // Short low glitch: false start, no strobe.
        rxd = 1'b0;
        #600;
        rxd = 1'b1;
        #800;
        check("glitch_busy_high", {31'd0, busy}, 1);
        #1200;
        check("glitch_busy_low", {31'd0, busy}, 0);
        #(BIT_NS * 2);

        // 8'h3C with a low stop bit, line held low afterwards.
        expect_ev(1, last_good);
        send_frame(8'h3C, 1'b0, 1'b0);
        check("ferr_busy_hold", {31'd0, busy}, 1);
        check("ferr_data_kept", {24'd0, data}, {24'd0, last_good});
        #(BIT_NS * 2);
        check("ferr_busy_wait", {31'd0, busy}, 1);
        rxd = 1'b1;
        #(BIT_NS);
        check("ferr_busy_release", {31'd0, busy}, 0);
        #(BIT_NS);

        // Reset pulse halfway through data bit 3 of 8'h5A (0,1,0,1 so far).
        rxd = 1'b0; #(BIT_NS);
        rxd = 1'b0; #(BIT_NS);
        rxd = 1'b1; #(BIT_NS);
        rxd = 1'b0; #(BIT_NS);
        rxd = 1'b1; #(BIT_NS / 2);
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_data", {24'd0, data}, 0);
        #39;
        reset = 1'b1;
        last_good = 8'h00;
        #(BIT_NS * 3);
        check("midrst_idle", {31'd0, busy}, 0);

        // Clean 8'h5A afterwards.
        expect_ev(0, 8'h5A);
        last_good = 8'h5A;
        send_frame(8'h5A, 1'b1, 1'b0);
        #(BIT_NS);

`ifdef UART_RX_PARITY_EN
        // 8'h5A has even parity bit 0; send 1 instead.
        expect_ev(2, last_good);
        send_frame(8'h5A, 1'b1, 1'b1);
        #(BIT_NS);
        check("perr_data_kept", {24'd0, data}, 8'h5A);
`endif

        #(BIT_NS * 2);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_busy", {31'd0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
